// File: rtl/store_merge_pkg.sv
// Shared definitions for the store merge unit: FSM state encodings, store size
// encodings and the alignment rule used to reject a store before any memory access.
package store_merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SIZE_WORD    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_BYTE    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  // True when the store cannot be performed: illegal size, or a word/half that
  // is not naturally aligned.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_WORD: mis = (offset != 2'b00);
      SIZE_HALF: mis = offset[0];
      SIZE_BYTE: mis = 1'b0;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane merge for sub-word stores.
//   word   : memory word read back (lanes to preserve)
//   data   : register value being stored (low 8/16 bits used for byte/half)
//   size   : store size encoding
//   offset : byte offset of the store within the word
//   merged : word to write back; for a word store this is data unchanged
module byte_lane_merge
  import store_merge_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  size_e       size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = word;
    case (size)
      SIZE_BYTE: merged[{offset, 3'b000} +: 8]     = data[7:0];
      SIZE_HALF: merged[{offset[1], 4'b0000} +: 16] = data[15:0];
      default:   merged = data;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store-side narrowing unit: writes a byte or half of a register into memory by
// read-modify-write; word stores are written directly, misaligned or illegal
// stores complete immediately with an exception flag.
//   clk, reset (sync, active-high)
//   start, store_size, address, store_data : request, sampled only in IDLE
//   mem_rdata                              : read data, valid MEM_LATENCY cycles after address
//   mem_addr, mem_wr, mem_wdata            : memory port
//   busy, done, misaligned                 : status; misaligned valid only with done
module store_merge_unit
  import store_merge_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  // READ spans wait counts 0..MEM_LATENCY, i.e. MEM_LATENCY+1 cycles.
  localparam logic [2:0] LastWait = 3'(MEM_LATENCY);

  state_e      state_q;
  logic [2:0]  wait_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] merge_q;
  size_e       size_q;

  logic  start_mis;
  size_e start_size;

  assign start_size = size_e'(store_size);
  assign start_mis  = is_misaligned(start_size, address[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      merge_q    <= '0;
      size_q     <= SIZE_WORD;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_wr     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      // Pulsed outputs default low; each state raises what the next cycle needs.
      done       <= 1'b0;
      mem_wr     <= 1'b0;
      misaligned <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q <= address;
            data_q <= store_data;
            size_q <= start_size;
            wait_q <= '0;
            busy   <= 1'b1;
            if (start_mis) begin
              state_q    <= ST_DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else if (start_size == SIZE_WORD) begin
              state_q <= ST_WRITE;
              mem_wr  <= 1'b1;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (wait_q == LastWait) begin
            merge_q <= mem_rdata;
            state_q <= ST_WRITE;
            mem_wr  <= 1'b1;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        ST_WRITE: begin
          state_q <= ST_DONE;
          done    <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = {addr_q[31:2], 2'b00};

  // Word stores bypass the merge inside byte_lane_merge, so mem_wdata is data_q.
  byte_lane_merge u_byte_lane_merge (
    .word   (merge_q),
    .data   (data_q),
    .size   (size_q),
    .offset (addr_q[1:0]),
    .merged (mem_wdata)
  );

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  localparam logic [31:0] MemWord = 32'h1122_3344;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  store_size;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        start_a, start_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
  logic        mem_wr_a, mem_wr_b, busy_a, busy_b, done_a, done_b, mis_a, mis_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_wr;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          mis;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_merge_unit #(.MEM_LATENCY(1)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .store_size (store_size),
    .address    (address),
    .store_data (store_data),
    .mem_rdata  (rdata_a),
    .mem_addr   (mem_addr_a),
    .mem_wr     (mem_wr_a),
    .mem_wdata  (mem_wdata_a),
    .busy       (busy_a),
    .done       (done_a),
    .misaligned (mis_a)
  );

  store_merge_unit #(.MEM_LATENCY(3)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .store_size (store_size),
    .address    (address),
    .store_data (store_data),
    .mem_rdata  (rdata_b),
    .mem_addr   (mem_addr_b),
    .mem_wr     (mem_wr_b),
    .mem_wdata  (mem_wdata_b),
    .busy       (busy_b),
    .done       (done_b),
    .misaligned (mis_b)
  );

  // Memory models: read data becomes valid MEM_LATENCY cycles after the address
  // is presented; junk is returned for anything fetched while idle.
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a    <= busy_a ? MemWord : (32'hBAD0_BAD0 ^ cyc);
    pipe_b[0] <= busy_b ? MemWord : (32'hBAD1_BAD1 ^ cyc);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_a = pipe_a;
  assign rdata_b = pipe_b[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] d);
    logic [31:0] mask;
    logic [4:0]  sh;
    if (sz == 2'b00) return d;
    if (sz == 2'b10) begin
      sh   = {a[1:0], 3'b000};
      mask = 32'h0000_00FF << sh;
    end else begin
      sh   = {a[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
    end
    return (MemWord & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
  endfunction

  task automatic cmp(input string who, input exp_t e, input logic wr, input logic dn,
                     input logic mis, input logic [31:0] addr, input logic [31:0] wdata);
    check({who, "_kind"}, {30'd0, wr, dn}, e.is_wr ? 32'd2 : 32'd1);
    check({who, "_cycle"}, cyc, e.cyc);
    if (e.is_wr) begin
      check({who, "_addr"}, addr, e.addr);
      check({who, "_wdata"}, wdata, e.wdata);
    end else begin
      check({who, "_mis"}, {31'd0, mis}, {31'd0, e.mis});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_wr_a || done_a) begin
      if (q_a.size() == 0) check("spurious_a", 1, 0);
      else begin
        e = q_a.pop_front();
        cmp("a", e, mem_wr_a, done_a, mis_a, mem_addr_a, mem_wdata_a);
      end
    end
    if (mem_wr_b || done_b) begin
      if (q_b.size() == 0) check("spurious_b", 1, 0);
      else begin
        e = q_b.pop_front();
        cmp("b", e, mem_wr_b, done_b, mis_b, mem_addr_b, mem_wdata_b);
      end
    end
    if (!done_a) check("mis_nodone_a", {31'd0, mis_a}, 0);
    if (!done_b) check("mis_nodone_b", {31'd0, mis_b}, 0);
  end

  // Drives one request and pushes its expected events; returns #1 into cycle 1.
  task automatic issue(input bit use_b, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    int   acc;
    int   lat;
    @(posedge clk);
    #1;
    store_size = sz;
    address    = a;
    store_data = d;
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    address    = $urandom;
    store_data = $urandom;
    store_size = 2'($urandom_range(0, 3));
    acc = cyc;
    lat = use_b ? 3 : 1;
    e.addr  = {a[31:2], 2'b00};
    e.wdata = model_wdata(sz, a, d);
    e.mis   = 1'b0;
    if (model_mis(sz, a)) begin
      e.is_wr = 1'b0; e.cyc = acc; e.mis = 1'b1;
      if (use_b) q_b.push_back(e); else q_a.push_back(e);
    end else begin
      e.is_wr = 1'b1;
      e.cyc   = (sz == 2'b00) ? acc : acc + lat + 1;
      if (use_b) q_b.push_back(e); else q_a.push_back(e);
      e.is_wr = 1'b0;
      e.cyc   = e.cyc + 1;
      if (use_b) q_b.push_back(e); else q_a.push_back(e);
    end
  endtask

  task automatic wait_idle(input bit use_b);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(use_b ? busy_b : busy_a)) break;
    end
    check(use_b ? "idle_timeout_b" : "idle_timeout_a", {31'd0, use_b ? busy_b : busy_a}, 0);
    check(use_b ? "pending_b" : "pending_a", use_b ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin
    reset      = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    store_size = 2'b00;
    address    = '0;
    store_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy_a", {31'd0, busy_a}, 0);
    check("rst_done_a", {31'd0, done_a}, 0);
    check("rst_wr_a", {31'd0, mem_wr_a}, 0);
    check("rst_addr_a", mem_addr_a, 0);
    check("rst_wdata_a", mem_wdata_a, 0);
    check("rst_busy_b", {31'd0, busy_b}, 0);
    check("rst_wdata_b", mem_wdata_b, 0);

    // Directed cases on the latency-1 instance.
    issue(0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_idle(0);
    issue(0, 2'b10, 32'h0000_0013, 32'hFFFF_FFA5);
    @(negedge clk);
    check("sb_read_busy", {31'd0, busy_a}, 1);
    wait_idle(0);
    issue(0, 2'b01, 32'h0000_0022, 32'h0000_CAFE);
    wait_idle(0);
    issue(0, 2'b01, 32'h0000_0021, 32'h0000_CAFE);
    wait_idle(0);
    issue(0, 2'b11, 32'h0000_0020, 32'h1234_5678);
    wait_idle(0);
    issue(0, 2'b00, 32'h0000_0012, 32'h1234_5678);
    wait_idle(0);
    issue(0, 2'b10, 32'h0000_0040, 32'h0000_0077);
    wait_idle(0);

    // Random stores on the latency-1 instance.
    for (int i = 0; i < 16; i++) begin
      issue(0, 2'($urandom_range(0, 3)), $urandom, $urandom);
      wait_idle(0);
    end

    // Latency-3 byte store, with a start pulse during READ that must be dropped.
    issue(1, 2'b10, 32'h0000_0081, 32'h0000_00C3);
    check("b_busy_c1", {31'd0, busy_b}, 1);
    @(posedge clk);
    #1;
    start_b    = 1'b1;
    store_size = 2'b00;
    address    = 32'h0000_0100;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    check("b_busy_c3", {31'd0, busy_b}, 1);
    wait_idle(1);
    repeat (6) @(negedge clk);
    check("b_no_queue", {31'd0, busy_b}, 0);
    for (int i = 0; i < 4; i++) begin
      issue(1, 2'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC, $urandom);
      wait_idle(1);
    end

    // Reset in READ cycle 2 aborts the store with no write and no done.
    @(posedge clk);
    #1;
    store_size = 2'b10;
    address    = 32'h0000_0013;
    start_a    = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy_a}, 0);
    check("abort_addr", mem_addr_a, 0);
    repeat (5) @(negedge clk);
    check("abort_idle", {31'd0, busy_a}, 0);
    issue(0, 2'b00, 32'h0000_0030, 32'hA5A5_5A5A);
    wait_idle(0);

    check("final_pending_a", q_a.size(), 0);
    check("final_pending_b", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 Parameter MEM_LATENCY, default 1: cycles from a presented read address to valid mem_rdata; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  store request; sampled only in IDLE.
REQ-005 store_size  in  2  00 word (SW), 01 half (SH), 10 byte (SB), 11 illegal.
REQ-006 address  in  32  byte address of the store.
REQ-007 store_data  in  32  register value to store; only the low 8/16 bits are used for SB/SH.
REQ-008 mem_rdata  in  32  word read from memory.
REQ-009 mem_addr  out  32  word-aligned memory address, {addr_q[31:2],2'b00}.
REQ-010 mem_wr  out  1  memory write strobe.
REQ-011 mem_wdata  out  32  full word to write.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 misaligned  out  1  alignment/illegal-size exception, valid only while done=1.

Function
REQ-015 The block SHALL be the store-side counterpart of the load-side extension: it narrows a 32-bit register into a byte or half lane of a memory word by read-modify-write.
REQ-016 The FSM SHALL have exactly these states: IDLE, READ, WRITE, DONE.
REQ-017 On an edge in IDLE with start=1, the block SHALL latch address, store_data and store_size into addr_q, data_q and size_q.
REQ-018 Misaligned requests are: store_size=11; word with address[1:0]!=0; half with address[0]=1.
REQ-019 For a misaligned request the FSM SHALL go IDLE->DONE, SHALL never assert mem_wr, and SHALL assert misaligned=1 together with done.
REQ-020 For an aligned word request the FSM SHALL go IDLE->WRITE->DONE, with mem_wdata=data_q and no read.
REQ-021 For an aligned byte or half request the FSM SHALL go IDLE->READ->WRITE->DONE.
REQ-022 READ SHALL last exactly MEM_LATENCY+1 cycles, counted by a wait counter that is cleared on entry.
REQ-023 mem_rdata SHALL be captured into merge_q at the edge that ends the last READ cycle.
REQ-024 Byte merge, k=addr_q[1:0]: merged word = merge_q with bits [8k+7:8k] replaced by data_q[7:0].
REQ-025 Half merge: addr_q[1]=0 replaces bits [15:0] with data_q[15:0]; addr_q[1]=1 replaces bits [31:16] with data_q[15:0].
REQ-026 In every merge, all bytes outside the target lane SHALL be preserved exactly.
REQ-027 WRITE SHALL last exactly one cycle, with mem_wr=1 and mem_wdata equal to the word or merged value.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a new start is accepted in the cycle after DONE.
REQ-029 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-030 Outputs SHALL be registered or decoded from state only; no combinational path from any input to any output.
REQ-031 mem_addr SHALL hold the aligned latched address from the cycle after acceptance until the next acceptance.
REQ-032 mem_wr SHALL be 0 in all states except WRITE.
REQ-033 misaligned SHALL be 0 whenever done=0.
REQ-034 Latency from the accepting edge to done, where cycle 1 is the cycle after that edge:
  - misaligned: cycle 1
  - word: done in cycle 2
  - byte/half: done in cycle MEM_LATENCY+3

Reset
REQ-035 While reset=1 at an edge, the FSM SHALL enter IDLE, and the wait counter, addr_q, data_q, merge_q, mem_addr and mem_wdata SHALL clear to 0.
REQ-036 Reset SHALL take priority over start and over all in-progress states.
REQ-037 Reset during READ or WRITE SHALL abort with no further mem_wr and no done pulse.
REQ-038 After reset, busy, done, mem_wr and misaligned SHALL all be 0.

Structure
REQ-039 Shared package store_merge_pkg SHALL hold:
  - state encodings ST_IDLE, ST_READ, ST_WRITE, ST_DONE
  - size encodings SIZE_WORD=00, SIZE_HALF=01, SIZE_BYTE=10
REQ-040 Lane merging SHALL live in one combinational sub-module, byte_lane_merge (inputs: word, data, size, offset; output: merged word).

Verification
REQ-041 SW: addr 0x00000010, data 0xDEADBEEF -> cycle 1 mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2 done=1, misaligned=0; no READ cycles.
REQ-042 SB, MEM_LATENCY=1: addr 0x00000013, data 0xFFFFFFA5, mem_rdata=0x11223344 -> READ cycles 1-2, cycle 3 mem_wr=1, mem_addr=0x10, mem_wdata=0x11223344 with bits [31:24] replaced by 0xA5 (=0xA5223344); cycle 4 done=1.
REQ-043 SH: addr 0x22, data 0x0000CAFE, mem_rdata 0x11223344 -> mem_wdata=0xCAFE3344, mem_addr=0x20.
REQ-044 SH at addr 0x21, and size=11 at addr 0x20 -> cycle 1 done=1, misaligned=1, mem_wr never asserted.
REQ-045 SB with MEM_LATENCY=3 -> READ exactly 4 cycles, done in cycle 6; start pulsed during READ is ignored, busy stays 1.
REQ-046 reset=1 in READ cycle 2 -> next cycle IDLE, busy=0, mem_wr and done never assert; a subsequent SW completes normally.
